dmem_cache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache sitting between the memory stage and the multi-cycle backing data memory. Hits complete combinationally in the request cycle. Misses stall the pipeline while an FSM evicts dirty lines and fills four-word lines over a req/ack word interface. The memory stage sees a single `Done`/`Stall` pair and never talks to backing memory directly.

---
 rtl/dmem_cache_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_dmem_cache_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_cache_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_cache_ctrl
//   Direct-mapped, write-back, write-allocate data cache between the memory
//   stage and a multi-cycle backing memory. Hits complete in the request cycle;
//   misses stall while the FSM evicts a dirty victim and fills a 4-word line
//   over a req/ack word interface.
//
// Parameters
//   LINES      number of lines (power of two), index = Addr[log2(LINES)+2:3]
//   WORDS      16-bit words per line (fixed at 4), word = Addr[2:1]
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   Addr, DataIn          byte address / store data from the memory stage
//   Rd, Wr                load / store request (held while Stall=1)
//   DataOut               load data, valid with Done & Rd
//   Done, Stall           request completes / pipeline freeze
//   CacheHit              request hit with no memory traffic
//   err                   illegal request (Rd&Wr, or odd address)
//   mem_addr, mem_wdata   word-aligned backing-memory address / eviction data
//   mem_rd, mem_wr        backing-memory read / write, held until mem_ack
//   mem_rdata, mem_ack    fill data / one-cycle word acknowledge
//
// Optional feature macro: DCACHE_STATS_EN
//   Adds hit_count / miss_count outputs (16-bit saturating counters).
// -----------------------------------------------------------------------------
module dmem_cache_ctrl #(
    parameter int unsigned LINES = 32,
    parameter int unsigned WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 16 - 3 - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        EVICT,
        FILL,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;

    // Tag and data arrays carry no reset; the valid bits gate their use.
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [15:0]      data_q [LINES][WORDS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       word;
    logic             req;
    logic             illegal;
    logic             hit;
    logic             miss_det;

    // Single data-array write port shared by store hits, fills and merges.
    logic             dw_en;
    logic [1:0]       dw_word;
    logic [15:0]      dw_data;
    logic             tag_we;

    assign idx     = Addr[IDX_W+2:3];
    assign tag     = Addr[15:IDX_W+3];
    assign word    = Addr[2:1];
    assign req     = Rd | Wr;
    assign illegal = (Rd & Wr) | (Addr[0] & req);
    assign hit     = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        dw_en     = 1'b0;
        dw_word   = word;
        dw_data   = DataIn;
        tag_we    = 1'b0;
        miss_det  = 1'b0;
        DataOut   = '0;
        Done      = 1'b0;
        Stall     = 1'b0;
        CacheHit  = 1'b0;
        err       = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;

        // Outputs are held at their reset values for as long as rst is high,
        // even if the pipeline keeps a request asserted.
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (illegal) begin
                        err = 1'b1;
                    end else if (req) begin
                        if (hit) begin
                            Done     = 1'b1;
                            CacheHit = 1'b1;
                            if (Rd) begin
                                DataOut = data_q[idx][word];
                            end else begin
                                dw_en        = 1'b1;
                                dirty_d[idx] = 1'b1;
                            end
                        end else begin
                            Stall    = 1'b1;
                            miss_det = 1'b1;
                            cnt_d    = '0;
                            state_d  = (valid_q[idx] && dirty_q[idx]) ? EVICT : FILL;
                        end
                    end
                end

                EVICT: begin
                    Stall     = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = {tag_q[idx], idx, cnt_q, 1'b0};
                    mem_wdata = data_q[idx][cnt_q];
                    if (mem_ack) begin
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            dirty_d[idx] = 1'b0;
                            state_d      = FILL;
                        end
                    end
                end

                FILL: begin
                    Stall    = 1'b1;
                    mem_rd   = 1'b1;
                    mem_addr = {tag, idx, cnt_q, 1'b0};
                    if (mem_ack) begin
                        dw_en   = 1'b1;
                        dw_word = cnt_q;
                        dw_data = mem_rdata;
                        cnt_d   = cnt_q + 2'd1;
                        // The line only becomes valid once all four words are in.
                        if (cnt_q == 2'd3) begin
                            valid_d[idx] = 1'b1;
                            dirty_d[idx] = 1'b0;
                            tag_we       = 1'b1;
                            state_d      = RESP;
                        end
                    end
                end

                RESP: begin
                    Done = 1'b1;
                    if (Rd) begin
                        DataOut = data_q[idx][word];
                    end else if (Wr) begin
                        dw_en        = 1'b1;
                        dirty_d[idx] = 1'b1;
                    end
                    state_d = IDLE;
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (dw_en) begin
            data_q[idx][dw_word] <= dw_data;
        end
        if (tag_we) begin
            tag_q[idx] <= tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (CacheHit && (hit_count_q != '1)) begin
                hit_count_q <= hit_count_q + 16'd1;
            end
            if (miss_det && (miss_count_q != '1)) begin
                miss_count_q <= miss_count_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dmem_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_cache_ctrl
//   Table-driven vectors for single-cycle hits / illegal requests, plus
//   hand-written sequences for misses, evictions, reset mid-fill and slow ack.
// -----------------------------------------------------------------------------
module tb_dmem_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    dmem_cache_ctrl #(.LINES(32), .WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .Addr      (Addr),
        .DataIn    (DataIn),
        .Rd        (Rd),
        .Wr        (Wr),
        .DataOut   (DataOut),
        .Done      (Done),
        .Stall     (Stall),
        .CacheHit  (CacheHit),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- backing memory model ----------------
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    logic [15:0] mem [0:32767];
    txn_t        txn_q[$];
    int          ack_delay   = 0;
    int          wait_cnt    = 0;
    int          stable_errs = 0;
    int          both_errs   = 0;
    logic        prev_ack    = 1'b0;
    logic        prev_act    = 1'b0;
    logic [15:0] prev_addr   = '0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            prev_ack = mem_ack;
            mem_ack  = 1'b0;
            if (rst || !(mem_rd || mem_wr)) begin
                wait_cnt = 0;
                prev_act = 1'b0;
            end else begin
                if (prev_act && !prev_ack && (mem_addr !== prev_addr)) stable_errs++;
                if (mem_rd && mem_wr) both_errs++;
                prev_act  = 1'b1;
                prev_addr = mem_addr;
                if (wait_cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    if (mem_wr) begin
                        mem[mem_addr[15:1]] = mem_wdata;
                        txn_q.push_back('{wr: 1'b1, addr: mem_addr, data: mem_wdata});
                    end else begin
                        mem_rdata = mem[mem_addr[15:1]];
                        txn_q.push_back('{wr: 1'b0, addr: mem_addr, data: mem_rdata});
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic chk_txn(input string name, input int i, input logic wr,
                           input logic [15:0] a, input logic [15:0] d);
        if (i >= txn_q.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: transaction %0d missing (got %0d transactions)", name, i, txn_q.size());
        end else begin
            chk(name, {txn_q[i].wr, txn_q[i].addr, txn_q[i].data}, {wr, a, d});
        end
    endtask

    // ---------------- access driver ----------------
    int          acc_cycles;
    int          acc_stall;
    logic [15:0] acc_dout;
    logic        acc_hit;
    logic        acc_done;
    logic        acc_stall_at_done;

    // Presents one request and waits (bounded) for Done, then drops it.
    task automatic do_access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        txn_q.delete();
        @(negedge clk);
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        acc_cycles = 0; acc_stall = 0; acc_done = 1'b0;
        acc_dout = '0; acc_hit = 1'b0; acc_stall_at_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            acc_cycles++;
            if (Stall) acc_stall++;
            if (Done) begin
                acc_done          = 1'b1;
                acc_dout          = DataOut;
                acc_hit           = CacheHit;
                acc_stall_at_done = Stall;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        Rd = 1'b0; Wr = 1'b0;
    endtask

    task automatic check_access(input string name, input int exp_cycles, input int exp_stall,
                                input logic exp_hit, input logic chk_dout, input logic [15:0] exp_dout);
        chk({name, ".done"}, acc_done, 1'b1);
        chk({name, ".cycles"}, acc_cycles, exp_cycles);
        chk({name, ".stall_cycles"}, acc_stall, exp_stall);
        chk({name, ".hit"}, acc_hit, exp_hit);
        chk({name, ".stall_at_done"}, acc_stall_at_done, 1'b0);
        if (chk_dout) chk({name, ".dout"}, acc_dout, exp_dout);
    endtask

    // ---------------- single-cycle vector table ----------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        done;
        logic        stall;
        logic        hit;
        logic        err;
        logic        chk_dout;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic found;

        // line at index 2 holds tag 0x00 = A000..A003 when the table runs
        vecs[0] = '{1'b1, 1'b0, 16'h0016, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA003};
        vecs[1] = '{1'b0, 1'b1, 16'h0014, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0014, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234};
        vecs[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA000};
        vecs[4] = '{1'b1, 1'b1, 16'h0010, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};
        vecs[6] = '{1'b0, 1'b1, 16'h0011, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};
        vecs[7] = '{1'b0, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[8] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA000};
        vecs[9] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA001};

        for (int i = 0; i < 32768; i++) mem[i] = '0;
        for (int w = 0; w < 4; w++) begin
            mem[(16'h0010 >> 1) + w] = 16'hA000 + 16'(w);
            mem[(16'h1010 >> 1) + w] = 16'hB000 + 16'(w);
            mem[(16'h0200 >> 1) + w] = 16'hC000 + 16'(w);
            mem[(16'h0410 >> 1) + w] = 16'hD000 + 16'(w);
            mem[(16'h0610 >> 1) + w] = 16'hE000 + 16'(w);
            mem[(16'h0300 >> 1) + w] = 16'hF000 + 16'(w);
        end

        rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;

        // ---- reset state ----
        #1;
        chk("reset.ctrl", {Done, Stall, CacheHit, err, mem_rd, mem_wr}, 6'b0);
        chk("reset.dout", DataOut, 16'h0000);
        chk("reset.mem_addr", mem_addr, 16'h0000);
        chk("reset.mem_wdata", mem_wdata, 16'h0000);
`ifdef DCACHE_STATS_EN
        chk("reset.stats", {hit_count, miss_count}, 32'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---- clean read miss 0x0010 ----
        do_access(1'b1, 1'b0, 16'h0010, 16'h0);
        check_access("clean_rd_miss", 6, 5, 1'b0, 1'b1, 16'hA000);
        chk("clean_rd_miss.ntxn", txn_q.size(), 4);
        for (int w = 0; w < 4; w++)
            chk_txn("clean_rd_miss.fill", w, 1'b0, 16'h0010 + 16'(2 * w), 16'hA000 + 16'(w));

        // ---- re-read hit 0x0012 ----
        do_access(1'b1, 1'b0, 16'h0012, 16'h0);
        check_access("reread_hit", 1, 0, 1'b1, 1'b1, 16'hA001);
        chk("reread_hit.ntxn", txn_q.size(), 0);
`ifdef DCACHE_STATS_EN
        chk("stats.hit_count", hit_count, 16'd1);
        chk("stats.miss_count", miss_count, 16'd1);
`endif

        // ---- vector table: hits, illegal requests, no request ----
        txn_q.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            Rd = vecs[i].rd; Wr = vecs[i].wr; Addr = vecs[i].addr; DataIn = vecs[i].din;
            #1;
            chk($sformatf("vec%0d.done", i), Done, vecs[i].done);
            chk($sformatf("vec%0d.stall", i), Stall, vecs[i].stall);
            chk($sformatf("vec%0d.hit", i), CacheHit, vecs[i].hit);
            chk($sformatf("vec%0d.err", i), err, vecs[i].err);
            chk($sformatf("vec%0d.memreq", i), {mem_rd, mem_wr}, 2'b00);
            if (vecs[i].chk_dout) chk($sformatf("vec%0d.dout", i), DataOut, vecs[i].dout);
        end
        @(negedge clk);
        Rd = 1'b0; Wr = 1'b0;
        chk("vec.no_traffic", txn_q.size(), 0);

        // ---- dirty read miss 0x1014 (evicts tag 0x00 line) ----
        do_access(1'b1, 1'b0, 16'h1014, 16'h0);
        check_access("dirty_rd_miss", 10, 9, 1'b0, 1'b1, 16'hB002);
        chk("dirty_rd_miss.ntxn", txn_q.size(), 8);
        chk_txn("dirty_rd_miss.evict0", 0, 1'b1, 16'h0010, 16'hA000);
        chk_txn("dirty_rd_miss.evict1", 1, 1'b1, 16'h0012, 16'hA001);
        chk_txn("dirty_rd_miss.evict2", 2, 1'b1, 16'h0014, 16'h1234);
        chk_txn("dirty_rd_miss.evict3", 3, 1'b1, 16'h0016, 16'hA003);
        for (int w = 0; w < 4; w++)
            chk_txn("dirty_rd_miss.fill", 4 + w, 1'b0, 16'h1010 + 16'(2 * w), 16'hB000 + 16'(w));

        // ---- write miss 0x0200 <- BEEF, then hits, then eviction shows dirty ----
        do_access(1'b0, 1'b1, 16'h0200, 16'hBEEF);
        check_access("wr_miss", 6, 5, 1'b0, 1'b0, 16'h0);
        do_access(1'b1, 1'b0, 16'h0200, 16'h0);
        check_access("wr_miss.reread0", 1, 0, 1'b1, 1'b1, 16'hBEEF);
        do_access(1'b1, 1'b0, 16'h0202, 16'h0);
        check_access("wr_miss.reread1", 1, 0, 1'b1, 1'b1, 16'hC001);
        do_access(1'b1, 1'b0, 16'h0300, 16'h0);
        check_access("wr_miss.evict", 10, 9, 1'b0, 1'b1, 16'hF000);
        chk_txn("wr_miss.evict_w0", 0, 1'b1, 16'h0200, 16'hBEEF);
        chk_txn("wr_miss.evict_w3", 3, 1'b1, 16'h0206, 16'hC003);

        // ---- reset during FILL word 2 ----
        txn_q.delete();
        found = 1'b0;
        @(negedge clk);
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0410;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (mem_rd && (mem_addr == 16'h0414)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_fill.reached_word2", found, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_fill.ctrl", {Done, Stall, CacheHit, err, mem_rd, mem_wr}, 6'b0);
        chk("rst_fill.mem_addr", mem_addr, 16'h0000);
        chk("rst_fill.dout", DataOut, 16'h0000);
        @(negedge clk);
        Rd = 1'b0;
        rst = 1'b0;
        do_access(1'b1, 1'b0, 16'h0410, 16'h0);
        check_access("rst_fill.reread", 6, 5, 1'b0, 1'b1, 16'hD000);
        chk_txn("rst_fill.refill0", 0, 1'b0, 16'h0410, 16'hD000);

        // ---- slow ack: 3 wait cycles per word ----
        ack_delay   = 3;
        stable_errs = 0;
        do_access(1'b1, 1'b0, 16'h0610, 16'h0);
        check_access("slow_ack", 18, 17, 1'b0, 1'b1, 16'hE000);
        chk("slow_ack.ntxn", txn_q.size(), 4);
        for (int w = 0; w < 4; w++)
            chk_txn("slow_ack.fill", w, 1'b0, 16'h0610 + 16'(2 * w), 16'hE000 + 16'(w));
        chk("slow_ack.addr_stable", stable_errs, 0);
        ack_delay = 0;
        do_access(1'b1, 1'b0, 16'h0616, 16'h0);
        check_access("slow_ack.reread", 1, 0, 1'b1, 1'b1, 16'hE003);

        chk("mem_rd_wr_exclusive", both_errs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
